// File: rtl/lmb_arb_pkg.sv
// Shared types and helpers for the two-port LMB RAM arbiter.
package lmb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MERGE = 2'd1,
    RESP  = 2'd2
  } state_e;

  localparam logic [3:0] STRB_FULL = 4'b1111;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Naturally aligned bytes, halfwords and the full word only.
  function automatic logic strobe_legal(input logic [3:0] strobe);
    case (strobe)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: strobe_legal = 1'b1;
      default:                   strobe_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lmb_byte_merge.sv
// Per-lane select between old and new data under a byte strobe (combinational).
module lmb_byte_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   new_data,
  input  logic [DATA_WIDTH/8-1:0] strobe,
  output logic [DATA_WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_data;
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (strobe[i]) merged[8*i +: 8] = new_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/lmb_port_arbiter.sv
// Round-robin sharing of one LMB block RAM between the core data port (m0)
// and the boot/debug port (m1); sub-word writes become read-merge-write.
//
// state | meaning
// IDLE  | arbitrate; drive the RAM straight from the winning request
// MERGE | RAM read data back; write the merged word
// RESP  | completion pulse (ready/err/rdata) to the owner
module lmb_port_arbiter
  import lmb_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [3:0]            m0_strobe,
  input  logic [DATA_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic                  m0_ready,
  output logic                  m0_err,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [3:0]            m1_strobe,
  input  logic [DATA_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  m1_ready,
  output logic                  m1_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  gnt_id
);

  state_e                state_q, state_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  id_q, id_d;
  logic                  we_q, we_d;
  logic                  err_q, err_d;
  logic [3:0]            strobe_q, strobe_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  gnt_valid, gnt_sel;
  logic                  sel_we, sel_legal, sel_full;
  logic [3:0]            sel_strobe;
  logic [DATA_WIDTH-1:0] sel_addr, sel_wdata, sel_addr_al, merged;
  logic                  unused_addr_lsb;

  // Byte offset is carried by the strobe; only the word address matters.
  assign unused_addr_lsb = ^{m0_addr[1:0], m1_addr[1:0]};

  // Gating with rst keeps the req->mem path quiet while held in reset.
  assign gnt_valid   = rst & (m0_req | m1_req);
  assign gnt_sel     = (m0_req & m1_req) ? ~last_gnt_q : m1_req;
  assign sel_we      = gnt_sel ? m1_we     : m0_we;
  assign sel_strobe  = gnt_sel ? m1_strobe : m0_strobe;
  assign sel_addr    = gnt_sel ? m1_addr   : m0_addr;
  assign sel_wdata   = gnt_sel ? m1_wdata  : m0_wdata;
  assign sel_addr_al = {sel_addr[DATA_WIDTH-1:2], 2'b00};
  assign sel_legal   = strobe_legal(sel_strobe);
  assign sel_full    = (sel_strobe == STRB_FULL);

  lmb_byte_merge #(.DATA_WIDTH(DATA_WIDTH)) u_merge (
    .old_data (mem_rdata),
    .new_data (wdata_q),
    .strobe   (strobe_q),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      last_gnt_q <= M1;
      id_q       <= M0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      strobe_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      id_q       <= id_d;
      we_q       <= we_d;
      err_q      <= err_d;
      strobe_q   <= strobe_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    id_d       = id_q;
    we_d       = we_q;
    err_d      = err_q;
    strobe_d   = strobe_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          last_gnt_d = gnt_sel;
          id_d       = gnt_sel;
          we_d       = sel_we;
          err_d      = sel_we & ~sel_legal;
          strobe_d   = sel_strobe;
          addr_d     = sel_addr_al;
          wdata_d    = sel_wdata;
          state_d    = (sel_we & sel_legal & ~sel_full) ? MERGE : RESP;
        end
      end
      MERGE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    m0_ready  = 1'b0;
    m0_err    = 1'b0;
    m0_rdata  = '0;
    m1_ready  = 1'b0;
    m1_err    = 1'b0;
    m1_rdata  = '0;
    gnt_id    = id_q;
    case (state_q)
      IDLE: begin
        if (gnt_valid && (!sel_we || sel_legal)) begin
          mem_en   = 1'b1;
          mem_we   = sel_we & sel_full;
          mem_addr = sel_addr_al;
          if (sel_we && sel_full) mem_wdata = sel_wdata;
        end
      end
      MERGE: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q;
        mem_wdata = merged;
      end
      RESP: begin
        if (id_q == M0) begin
          m0_ready = 1'b1;
          m0_err   = err_q;
          if (!we_q) m0_rdata = mem_rdata;
        end else begin
          m1_ready = 1'b1;
          m1_err   = err_q;
          if (!we_q) m1_rdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lmb_port_arbiter.sv
// Directed bench for lmb_port_arbiter with a one-cycle-latency RAM model.
module tb_lmb_port_arbiter;

  logic        clk, rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [3:0]  m0_strobe, m1_strobe;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic        mem_en, mem_we, gnt_id;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] ram [0:1023];
  logic        ld_en;
  logic [9:0]  ld_idx;
  logic [31:0] ld_data;

  int checks = 0;
  int errors = 0;

  lmb_port_arbiter #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_strobe(m0_strobe), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_strobe(m1_strobe), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_err(m1_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .gnt_id(gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) ram[ld_idx] <= ld_data;
    else if (mem_en) begin
      if (mem_we) ram[mem_addr[11:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[11:2]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [31:0] byte_addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_idx  = byte_addr[11:2];
    ld_data = data;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic drive(input logic port, input logic we, input logic [3:0] strobe,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 1'b0) begin
      m0_req = 1'b1; m0_we = we; m0_strobe = strobe; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_strobe = strobe; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  initial begin
    rst = 1'b0;
    ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    mem_rdata = '0;
    m0_req = 0; m0_we = 0; m0_strobe = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_strobe = 0; m1_addr = 0; m1_wdata = 0;

    // Preload RAM while reset holds the DUT quiet.
    step();
    load(32'h100, 32'hDEADBEEF);
    load(32'h200, 32'h11223344);
    load(32'h300, 32'h00000000);
    sample();
    chk("rst_mem_en",   {31'd0, mem_en},   32'd0);
    chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("rst_gnt_id",   {31'd0, gnt_id},   32'd0);
    chk("rst_mem_addr", mem_addr,          32'd0);
    step();
    rst = 1'b1;
    step();

    // Read after reset: m0 reads 0x100.
    drive(1'b0, 1'b0, 4'b0000, 32'h100, 32'h0);
    sample();
    chk("rd_g_mem_en",  {31'd0, mem_en}, 32'd1);
    chk("rd_g_mem_we",  {31'd0, mem_we}, 32'd0);
    chk("rd_g_addr",    mem_addr,        32'h100);
    step();
    m0_req = 1'b0;
    sample();
    chk("rd_m0_ready",  {31'd0, m0_ready}, 32'd1);
    chk("rd_m0_rdata",  m0_rdata,          32'hDEADBEEF);
    chk("rd_m0_err",    {31'd0, m0_err},   32'd0);
    chk("rd_m1_ready",  {31'd0, m1_ready}, 32'd0);
    chk("rd_m1_rdata",  m1_rdata,          32'd0);
    step();
    sample();
    chk("rd_ready_pulse", {31'd0, m0_ready}, 32'd0);

    // Byte write RMW from m1.
    step();
    drive(1'b1, 1'b1, 4'b0100, 32'h202, 32'h00AA0000);
    sample();
    chk("rmw_g_mem_en", {31'd0, mem_en}, 32'd1);
    chk("rmw_g_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rmw_g_addr",   mem_addr,        32'h200);
    step();
    sample();
    chk("rmw_m_mem_we", {31'd0, mem_we}, 32'd1);
    chk("rmw_m_wdata",  mem_wdata,       32'h11AA3344);
    chk("rmw_m_addr",   mem_addr,        32'h200);
    chk("rmw_m_early",  {31'd0, m1_ready}, 32'd0);
    step();
    m1_req = 1'b0;
    sample();
    chk("rmw_m1_ready", {31'd0, m1_ready}, 32'd1);
    chk("rmw_m1_rdata", m1_rdata,          32'd0);
    chk("rmw_gnt_id",   {31'd0, gnt_id},   32'd1);
    chk("rmw_m0_ready", {31'd0, m0_ready}, 32'd0);
    step();
    chk("rmw_ram",      ram[10'h080],      32'h11AA3344);

    // Simultaneous requests right after a fresh reset: m0, m1, m0.
    rst = 1'b0;
    step();
    rst = 1'b1;
    drive(1'b0, 1'b0, 4'b0000, 32'h100, 32'h0);
    drive(1'b1, 1'b0, 4'b0000, 32'h200, 32'h0);
    sample();
    chk("arb1_addr",    mem_addr, 32'h100);
    step();
    sample();
    chk("arb1_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("arb1_m0_rdata", m0_rdata,          32'hDEADBEEF);
    chk("arb1_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("arb1_gnt",      {31'd0, gnt_id},   32'd0);
    step();
    sample();
    chk("arb2_addr",     mem_addr, 32'h200);
    step();
    sample();
    chk("arb2_m1_ready", {31'd0, m1_ready}, 32'd1);
    chk("arb2_m1_rdata", m1_rdata,          32'h11AA3344);
    chk("arb2_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("arb2_gnt",      {31'd0, gnt_id},   32'd1);
    step();
    sample();
    chk("arb3_addr",     mem_addr, 32'h100);
    step();
    m0_req = 1'b0;
    m1_req = 1'b0;
    sample();
    chk("arb3_gnt",      {31'd0, gnt_id},   32'd0);
    chk("arb3_m0_ready", {31'd0, m0_ready}, 32'd1);
    step();

    // Illegal strobe 0101 from m0.
    drive(1'b0, 1'b1, 4'b0101, 32'h100, 32'hFFFFFFFF);
    sample();
    chk("ill_mem_en",   {31'd0, mem_en}, 32'd0);
    step();
    m0_req = 1'b0;
    sample();
    chk("ill_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("ill_m0_err",   {31'd0, m0_err},   32'd1);
    chk("ill_m0_rdata", m0_rdata,          32'd0);
    step();
    chk("ill_ram",      ram[10'h040],      32'hDEADBEEF);

    // Empty strobe from m1 is also illegal.
    drive(1'b1, 1'b1, 4'b0000, 32'h200, 32'hFFFFFFFF);
    sample();
    chk("zero_mem_en",  {31'd0, mem_en}, 32'd0);
    step();
    m1_req = 1'b0;
    sample();
    chk("zero_m1_err",  {31'd0, m1_err}, 32'd1);
    chk("zero_m0_err",  {31'd0, m0_err}, 32'd0);
    step();

    // Reset asserted while in MERGE.
    drive(1'b0, 1'b1, 4'b0001, 32'h100, 32'h00000055);
    step();
    rst = 1'b0;
    m0_req = 1'b0;
    sample();
    chk("rstm_mem_we",  {31'd0, mem_we},   32'd0);
    chk("rstm_mem_en",  {31'd0, mem_en},   32'd0);
    chk("rstm_ready",   {31'd0, m0_ready}, 32'd0);
    chk("rstm_wdata",   mem_wdata,         32'd0);
    step();
    rst = 1'b1;
    chk("rstm_ram",     ram[10'h040],      32'hDEADBEEF);
    sample();
    chk("rstm_no_ready", {31'd0, m0_ready}, 32'd0);
    chk("rstm_idle_en",  {31'd0, mem_en},   32'd0);
    step();

    // Full-word then half-word write to 0x300.
    drive(1'b0, 1'b1, 4'b1111, 32'h300, 32'hCAFEF00D);
    sample();
    chk("full_mem_we",  {31'd0, mem_we}, 32'd1);
    chk("full_wdata",   mem_wdata,       32'hCAFEF00D);
    chk("full_addr",    mem_addr,        32'h300);
    step();
    m0_req = 1'b0;
    sample();
    chk("full_ready",   {31'd0, m0_ready}, 32'd1);
    chk("full_err",     {31'd0, m0_err},   32'd0);
    step();
    chk("full_ram",     ram[10'h0C0],      32'hCAFEF00D);
    drive(1'b0, 1'b1, 4'b1100, 32'h302, 32'hBEEF0000);
    sample();
    chk("half_g_we",    {31'd0, mem_we}, 32'd0);
    step();
    sample();
    chk("half_m_wdata", mem_wdata, 32'hBEEFF00D);
    step();
    m0_req = 1'b0;
    sample();
    chk("half_ready",   {31'd0, m0_ready}, 32'd1);
    step();
    chk("half_ram",     ram[10'h0C0],      32'hBEEFF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lmb_port_arbiter.md
# lmb_port_arbiter

Shares one single-port LMB block RAM between two requesters: the core data port (m0) and the boot-loader/debug port (m1). Round-robin arbitration decides which requester is served. Each granted transaction is sequenced through a small FSM, and sub-word writes are turned into an aligned read-merge-write pair. The block sits between the data-memory address decoder and the LMB RAM, replacing a direct connection to the RAM.

## Interface
- DATA_WIDTH, 32, data and address width; byte lanes = DATA_WIDTH/8 (must be 4)
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- mN_req  in  1  request, N = 0,1; held until mN_ready
- mN_we  in  1  1 = write, 0 = read
- mN_strobe  in  4  byte-lane write mask, lane-aligned
- mN_addr  in  DATA_WIDTH  byte address
- mN_wdata  in  DATA_WIDTH  write data, lane-aligned
- mN_rdata  out  DATA_WIDTH  read data, valid only while mN_ready=1 and it was a read
- mN_ready  out  1  one-cycle completion pulse
- mN_err  out  1  one-cycle pulse with mN_ready when the strobe is illegal
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write enable (full word)
- mem_addr  out  DATA_WIDTH  word-aligned address, [1:0] = 0
- mem_wdata  out  DATA_WIDTH  RAM write data
- mem_rdata  in  DATA_WIDTH  RAM read data, one-cycle latency after mem_en & !mem_we
- gnt_id  out  1  requester currently owning the RAM (valid outside IDLE)

## Operation

**FSM states**
- IDLE
  - If any req is high, grant per round-robin.
  - Latch we, strobe, addr, wdata and id into the transaction registers.
  - Drive the RAM from the granted request in this same cycle. This is a combinational path from req to mem_*.
- Read: mem_en=1, mem_we=0 -> RESP.
- Full write (strobe 1111): mem_en=1, mem_we=1, mem_wdata=wdata -> RESP.
- Sub-word write (legal partial strobe): aligned read, mem_en=1, mem_we=0 -> MERGE.
- Illegal strobe on a write: no RAM access -> RESP with err.
- MERGE
  - Merged word: lane i = latched wdata lane i if strobe[i], else mem_rdata lane i.
  - mem_en=1, mem_we=1, mem_addr = latched aligned address -> RESP.
- RESP
  - mN_ready=1 for the owner only.
  - On a read, mN_rdata = mem_rdata (pass-through); 0 otherwise.
  - -> IDLE.

**Strobe rules**
- Legal strobes: 0001, 0010, 0100, 1000, 0011, 1100, 1111.
- Any other strobe value on a write, including 0000, is illegal.
- Strobe is ignored on reads.

**Round-robin**
- last_gnt register, reset value 1, so m0 wins the first simultaneous request after reset.
- On simultaneous requests, grant the requester that is not last_gnt.
- last_gnt updates on every grant.

**Other rules**
- Non-owner mN_rdata, mN_ready and mN_err are held at 0.
- A request deasserted before ready still completes. The result is discarded by the requester.
- A requester may not change its request fields while waiting. The block uses latched copies after the grant anyway.

## Timing
- Reset values: every output is 0, FSM = IDLE, last_gnt = 1, transaction registers = 0.
- Reset asserted mid-transaction: return to IDLE immediately. The in-flight access is abandoned and no ready is issued. A half-done RMW leaves the RAM unmodified, because the write happens only in MERGE.
- Latency from the grant cycle G:
  - read, full write, illegal write: ready at G+1
  - sub-word write: ready at G+2
- Throughput: at most one transaction every 2 cycles (3 for RMW), since RESP always returns to IDLE.
- A losing requester is served in the IDLE cycle right after the winner's RESP, if it is still requesting.
- No combinational path from mem_rdata to mem_we or mem_en.

## Structure
- Package lmb_arb_pkg:
  - state enum: IDLE, MERGE, RESP
  - strobe constants: STRB_FULL=4'b1111
  - legal-strobe function
  - requester id constants: M0=0, M1=1
- Sub-module lmb_byte_merge: purely combinational per-lane mux of old and new data under strobe. It is reused by future cache write paths.
- FSM, round-robin and output muxing stay in lmb_port_arbiter.

## Test plan
- Read after reset:
  - Stimulus: m0 reads 0x100; RAM word 0x100 = 0xDEADBEEF.
  - Response: mem_en and addr 0x100 at G; m0_ready=1 and m0_rdata=0xDEADBEEF at G+1; m1 outputs stay 0.
- Byte write RMW:
  - Stimulus: RAM 0x200 = 0x11223344; m1 writes strobe 0100, addr 0x202, wdata 0x00AA0000.
  - Response: read at G; write of 0x11AA3344 at G+1; m1_ready at G+2.
- Simultaneous requests:
  - Stimulus: m0 and m1 both request right after reset.
  - Response: m0 granted first; m1 granted in the IDLE cycle after m0's RESP. With both held continuously, grants alternate m0, m1, m0.
- Illegal strobe:
  - Stimulus: m0 writes with strobe 0101.
  - Response: mem_en stays 0; m0_ready=1 and m0_err=1 at G+1; RAM unchanged.
- Reset during MERGE:
  - Stimulus: rst low in the cycle the FSM is in MERGE.
  - Response: mem_we=0, all outputs 0, FSM in IDLE, RAM word unchanged, no ready pulse.
- Full-word and half-word writes:
  - Stimulus: full write 0xCAFEF00D to 0x300, then half write strobe 1100, wdata 0xBEEF0000.
  - Response: full write completes with ready at G+1; RAM 0x300 ends as 0xBEEFF00D.
